// File: rtl/sdram_responder.sv
// sdram_responder: behavioural-but-synthesizable SDR SDRAM device model.
// It decodes the controller's command bus, tracks open rows per bank, and
// holds CAS latency from MRS. It stores write data in a small aliased array
// and returns read data after CL cycles, pulsing error on protocol faults.
module sdram_responder #(
  parameter int MEM_ROW_BITS = 2,
  parameter int MEM_COL_BITS = 4,
  parameter int TRCD         = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        clock_enable,
  input  logic        cs_n,
  input  logic        ras_n,
  input  logic        cas_n,
  input  logic        we_n,
  input  logic [12:0] addr,
  input  logic [1:0]  bank_addr,
  input  logic        data_mask_low,
  input  logic        data_mask_high,
  input  logic [15:0] dq_in,
  output logic [15:0] dq_out,
  output logic        dq_oe,
  output logic        init_done,
  output logic        error,
  output logic [2:0]  err_code,
  output logic [15:0] refresh_count
);

  localparam int IDX_W = 2 + MEM_ROW_BITS + MEM_COL_BITS;
  localparam int DEPTH = 1 << IDX_W;

  typedef enum logic [2:0] {
    CMD_NOP, CMD_PRE, CMD_REF, CMD_MRS, CMD_ACT, CMD_READ, CMD_WRITE
  } cmd_e;

  cmd_e                    cmd_s;
  logic [2:0]              err_s;
  logic                    accept_s;
  logic                    rd_acc_s;
  logic                    wr_acc_s;
  logic                    mrs_ok_s;
  logic [IDX_W-1:0]        idx_s;
  logic [15:0]             rd_data_s;
  logic                    unused_s;

  logic [3:0]              open_r;
  logic [3:0]              act_cnt_r [4];
  logic [MEM_ROW_BITS-1:0] row_r [4];
  logic                    cl3_r;
  logic                    v0_r, v1_r;
  logic [15:0]             d0_r, d1_r;
  logic [15:0]             mem_r [DEPTH];

  // Only a subset of address bits is meaningful for this shallow array.
  assign unused_s = ^addr;

  // Command decode; deselected or clock-gated cycles behave as NOP.
  always_comb begin
    cmd_s = CMD_NOP;
    if (clock_enable && !cs_n) begin
      case ({ras_n, cas_n, we_n})
        3'b010:  cmd_s = CMD_PRE;
        3'b001:  cmd_s = CMD_REF;
        3'b000:  cmd_s = CMD_MRS;
        3'b011:  cmd_s = CMD_ACT;
        3'b101:  cmd_s = CMD_READ;
        3'b100:  cmd_s = CMD_WRITE;
        default: cmd_s = CMD_NOP;
      endcase
    end else begin
      cmd_s = CMD_NOP;
    end
  end

  // Protocol checks; ordering gives the lowest applicable code priority.
  always_comb begin
    err_s    = 3'd0;
    mrs_ok_s = ((addr[6:4] == 3'd2) || (addr[6:4] == 3'd3)) && (addr[2:0] == 3'b000);
    case (cmd_s)
      CMD_REF: begin
        if (|open_r) err_s = 3'd5;
        else         err_s = 3'd0;
      end
      CMD_MRS: begin
        if (!mrs_ok_s || (|open_r)) err_s = 3'd6;
        else                        err_s = 3'd0;
      end
      CMD_ACT: begin
        if (!init_done)             err_s = 3'd1;
        else if (open_r[bank_addr]) err_s = 3'd3;
        else                        err_s = 3'd0;
      end
      CMD_READ, CMD_WRITE: begin
        if (!init_done)                                  err_s = 3'd1;
        else if (!open_r[bank_addr])                     err_s = 3'd2;
        else if (act_cnt_r[bank_addr] < 4'(TRCD))        err_s = 3'd4;
        else                                             err_s = 3'd0;
      end
      default: err_s = 3'd0;
    endcase
  end

  assign accept_s  = (err_s == 3'd0);
  assign rd_acc_s  = (cmd_s == CMD_READ) && accept_s;
  assign wr_acc_s  = (cmd_s == CMD_WRITE) && accept_s && !rst;
  assign idx_s     = {bank_addr, row_r[bank_addr], addr[MEM_COL_BITS-1:0]};
  assign rd_data_s = mem_r[idx_s];

  // Storage array; deliberately not reset so contents survive rst.
  always_ff @(posedge clk) begin
    if (wr_acc_s) begin
      if (!data_mask_high) mem_r[idx_s][15:8] <= dq_in[15:8];
      if (!data_mask_low)  mem_r[idx_s][7:0]  <= dq_in[7:0];
    end
  end

  // Bank, mode, counter, error and read-pipeline state.
  always_ff @(posedge clk) begin
    if (rst) begin
      open_r        <= 4'b0000;
      cl3_r         <= 1'b1;
      init_done     <= 1'b0;
      error         <= 1'b0;
      err_code      <= 3'd0;
      refresh_count <= 16'd0;
      v0_r          <= 1'b0;
      v1_r          <= 1'b0;
      d0_r          <= 16'h0000;
      d1_r          <= 16'h0000;
      dq_oe         <= 1'b0;
      dq_out        <= 16'h0000;
      for (int b = 0; b < 4; b++) begin
        act_cnt_r[b] <= 4'd0;
        row_r[b]     <= '0;
      end
    end else begin
      // Counter starts at 1 on ACT so its value at edge n equals n - a.
      for (int b = 0; b < 4; b++) begin
        if (act_cnt_r[b] != 4'hF) act_cnt_r[b] <= act_cnt_r[b] + 4'd1;
      end

      error <= (err_s != 3'd0);
      if (err_s != 3'd0) err_code <= err_s;

      // Stage data is forced to zero when invalid so dq_out idles at 0.
      v0_r   <= rd_acc_s;
      d0_r   <= rd_acc_s ? rd_data_s : 16'h0000;
      v1_r   <= v0_r;
      d1_r   <= d0_r;
      dq_oe  <= cl3_r ? v1_r : v0_r;
      dq_out <= cl3_r ? d1_r : d0_r;

      if (accept_s) begin
        case (cmd_s)
          CMD_PRE: begin
            if (addr[10]) open_r <= 4'b0000;
            else          open_r[bank_addr] <= 1'b0;
          end
          CMD_REF: refresh_count <= refresh_count + 16'd1;
          CMD_MRS: begin
            cl3_r     <= addr[4];
            init_done <= 1'b1;
          end
          CMD_ACT: begin
            open_r[bank_addr]    <= 1'b1;
            row_r[bank_addr]     <= addr[MEM_ROW_BITS-1:0];
            act_cnt_r[bank_addr] <= 4'd1;
          end
          CMD_READ, CMD_WRITE: begin
            if (addr[10]) open_r[bank_addr] <= 1'b0;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sdram_responder.sv
// Directed testbench for sdram_responder with hand-computed expectations.
module tb_sdram_responder;

  localparam logic [3:0] C_NOP = 4'b0111;
  localparam logic [3:0] C_PRE = 4'b0010;
  localparam logic [3:0] C_REF = 4'b0001;
  localparam logic [3:0] C_MRS = 4'b0000;
  localparam logic [3:0] C_ACT = 4'b0011;
  localparam logic [3:0] C_RD  = 4'b0101;
  localparam logic [3:0] C_WR  = 4'b0100;

  logic        clk = 1'b0;
  logic        rst;
  logic        clock_enable;
  logic        cs_n, ras_n, cas_n, we_n;
  logic [12:0] addr;
  logic [1:0]  bank_addr;
  logic        data_mask_low, data_mask_high;
  logic [15:0] dq_in;
  logic [15:0] dq_out;
  logic        dq_oe;
  logic        init_done;
  logic        error;
  logic [2:0]  err_code;
  logic [15:0] refresh_count;

  int tests_run = 0;
  int tests_failed = 0;

  sdram_responder dut (
    .clk(clk), .rst(rst), .clock_enable(clock_enable),
    .cs_n(cs_n), .ras_n(ras_n), .cas_n(cas_n), .we_n(we_n),
    .addr(addr), .bank_addr(bank_addr),
    .data_mask_low(data_mask_low), .data_mask_high(data_mask_high),
    .dq_in(dq_in), .dq_out(dq_out), .dq_oe(dq_oe),
    .init_done(init_done), .error(error), .err_code(err_code),
    .refresh_count(refresh_count)
  );

  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports mismatches.
  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Drive one command for one edge, then return the bus to NOP.
  task automatic issue(input logic [3:0] c, input logic [1:0] b, input logic [12:0] a);
    {cs_n, ras_n, cas_n, we_n} = c;
    bank_addr = b;
    addr = a;
    @(posedge clk);
    #1;
    {cs_n, ras_n, cas_n, we_n} = C_NOP;
    bank_addr = 2'd0;
    addr = 13'd0;
  endtask

  task automatic nop();
    issue(C_NOP, 2'd0, 13'd0);
  endtask

  initial begin
    rst = 1'b1;
    clock_enable = 1'b1;
    {cs_n, ras_n, cas_n, we_n} = C_NOP;
    addr = 13'd0;
    bank_addr = 2'd0;
    data_mask_low = 1'b0;
    data_mask_high = 1'b0;
    dq_in = 16'h0000;
    nop();
    nop();
    rst = 1'b0;

    // Reset state
    check_eq("rst_dq_oe", {31'd0, dq_oe}, 32'd0);
    check_eq("rst_dq_out", {16'd0, dq_out}, 32'd0);
    check_eq("rst_init_done", {31'd0, init_done}, 32'd0);
    check_eq("rst_error", {31'd0, error}, 32'd0);
    check_eq("rst_err_code", {29'd0, err_code}, 32'd0);
    check_eq("rst_refresh", {16'd0, refresh_count}, 32'd0);

    // ACT before MRS -> code 1, pulse lasts one cycle, code holds
    issue(C_ACT, 2'd0, 13'd0);
    check_eq("act_noinit_err", {31'd0, error}, 32'd1);
    check_eq("act_noinit_code", {29'd0, err_code}, 32'd1);
    nop();
    check_eq("err_pulse_end", {31'd0, error}, 32'd0);
    check_eq("err_code_hold", {29'd0, err_code}, 32'd1);

    // Init sequence
    issue(C_PRE, 2'd0, 13'h400);
    issue(C_REF, 2'd0, 13'd0);
    issue(C_REF, 2'd0, 13'd0);
    check_eq("init_before_mrs", {31'd0, init_done}, 32'd0);
    issue(C_MRS, 2'd0, 13'h230);
    check_eq("init_done", {31'd0, init_done}, 32'd1);
    check_eq("init_refresh", {16'd0, refresh_count}, 32'd2);
    check_eq("init_no_err", {31'd0, error}, 32'd0);

    // Write/read at CL3, auto-precharge on both
    issue(C_ACT, 2'd1, 13'd5);
    nop();
    nop();
    dq_in = 16'hBEEF;
    issue(C_WR, 2'd1, 13'h403);
    check_eq("wr_ok", {31'd0, error}, 32'd0);
    issue(C_ACT, 2'd1, 13'd5);
    check_eq("wr_autopre_closed", {31'd0, error}, 32'd0);
    nop();
    nop();
    issue(C_RD, 2'd1, 13'h403);
    check_eq("cl3_oe_n0", {31'd0, dq_oe}, 32'd0);
    nop();
    check_eq("cl3_oe_n1", {31'd0, dq_oe}, 32'd0);
    nop();
    check_eq("cl3_oe_n2", {31'd0, dq_oe}, 32'd1);
    check_eq("cl3_data", {16'd0, dq_out}, 32'h0000BEEF);
    nop();
    check_eq("cl3_oe_n3", {31'd0, dq_oe}, 32'd0);
    check_eq("cl3_idle_data", {16'd0, dq_out}, 32'd0);

    // READ to the auto-precharged (closed) bank -> code 2
    issue(C_RD, 2'd1, 13'h003);
    check_eq("rd_closed_err", {31'd0, error}, 32'd1);
    check_eq("rd_closed_code", {29'd0, err_code}, 32'd2);

    // Byte masks: 0x1234 then 0xABCD with low byte masked -> 0xAB34
    issue(C_ACT, 2'd2, 13'd1);
    nop();
    nop();
    dq_in = 16'h1234;
    issue(C_WR, 2'd2, 13'h007);
    dq_in = 16'hABCD;
    data_mask_low = 1'b1;
    issue(C_WR, 2'd2, 13'h007);
    data_mask_low = 1'b0;
    issue(C_RD, 2'd2, 13'h407);
    nop();
    nop();
    check_eq("mask_oe", {31'd0, dq_oe}, 32'd1);
    check_eq("mask_data", {16'd0, dq_out}, 32'h0000AB34);

    // READ only 2 cycles after ACT -> code 4, nothing returned
    issue(C_ACT, 2'd3, 13'd0);
    nop();
    issue(C_RD, 2'd3, 13'h000);
    check_eq("trcd_err", {31'd0, error}, 32'd1);
    check_eq("trcd_code", {29'd0, err_code}, 32'd4);
    for (int i = 0; i < 3; i++) begin
      nop();
      check_eq("trcd_no_oe", {31'd0, dq_oe}, 32'd0);
    end

    // MRS with a bank open -> code 6; REF with a bank open -> code 5, count unchanged
    issue(C_MRS, 2'd0, 13'h020);
    check_eq("mrs_open_code", {29'd0, err_code}, 32'd6);
    issue(C_REF, 2'd0, 13'd0);
    check_eq("ref_open_code", {29'd0, err_code}, 32'd5);
    check_eq("ref_open_count", {16'd0, refresh_count}, 32'd2);
    issue(C_PRE, 2'd3, 13'h000);

    // CL2 streaming of two back-to-back reads
    issue(C_MRS, 2'd0, 13'h020);
    check_eq("mrs_cl2_ok", {31'd0, error}, 32'd0);
    issue(C_ACT, 2'd1, 13'd5);
    nop();
    nop();
    dq_in = 16'h5A5A;
    issue(C_WR, 2'd1, 13'h004);
    issue(C_RD, 2'd1, 13'h003);
    check_eq("cl2_oe_n0", {31'd0, dq_oe}, 32'd0);
    issue(C_RD, 2'd1, 13'h404);
    check_eq("cl2_beat0_oe", {31'd0, dq_oe}, 32'd1);
    check_eq("cl2_beat0", {16'd0, dq_out}, 32'h0000BEEF);
    nop();
    check_eq("cl2_beat1_oe", {31'd0, dq_oe}, 32'd1);
    check_eq("cl2_beat1", {16'd0, dq_out}, 32'h00005A5A);
    nop();
    check_eq("cl2_end_oe", {31'd0, dq_oe}, 32'd0);

    // Reset one edge after a READ drops it; storage survives
    issue(C_MRS, 2'd0, 13'h230);
    issue(C_ACT, 2'd1, 13'd5);
    nop();
    nop();
    issue(C_RD, 2'd1, 13'h403);
    rst = 1'b1;
    nop();
    rst = 1'b0;
    check_eq("rstrd_init", {31'd0, init_done}, 32'd0);
    check_eq("rstrd_refresh", {16'd0, refresh_count}, 32'd0);
    check_eq("rstrd_code", {29'd0, err_code}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      check_eq("rstrd_no_oe", {31'd0, dq_oe}, 32'd0);
      nop();
    end
    issue(C_PRE, 2'd0, 13'h400);
    issue(C_MRS, 2'd0, 13'h230);
    check_eq("reinit_done", {31'd0, init_done}, 32'd1);
    issue(C_ACT, 2'd2, 13'd1);
    nop();
    nop();
    issue(C_RD, 2'd2, 13'h407);
    nop();
    nop();
    check_eq("retain_oe", {31'd0, dq_oe}, 32'd1);
    check_eq("retain_data", {16'd0, dq_out}, 32'h0000AB34);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/sdram_responder.md
# sdram_responder

Synthesizable single-rank SDR SDRAM device model that sits on the SDRAM side of `sdram_controller` and answers its command bus in place of the IS42S16160G-7 part, for simulation and on-FPGA loopback. It decodes commands, tracks per-bank open rows, programs CAS latency from MRS, and stores write data in a small aliased array. It returns read data after the programmed CAS latency and flags protocol violations for the bench.

## Interface
- `MEM_ROW_BITS`, 2: low row bits used in the storage index.
- `MEM_COL_BITS`, 4: low column bits used in the storage index; storage depth is 2^(2+MEM_ROW_BITS+MEM_COL_BITS) x 16.
- `TRCD`, 3: minimum cycles from ACT to READ/WRITE on the same bank.
- `clk`  in  1  clock; all state changes on its rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `clock_enable`, `cs_n`, `ras_n`, `cas_n`, `we_n`  in  1 each  command bus.
- `addr`  in  13  row on ACT; column on READ/WRITE, where A10 is auto-precharge; mode on MRS; A10 is all-banks on PRE.
- `bank_addr`  in  2  bank select.
- `data_mask_low`, `data_mask_high`  in  1 each  write byte masks; 1 = byte not written.
- `dq_in`  in  16  write data, sampled in the WRITE command cycle.
- `dq_out`  out  16  read data.
- `dq_oe`  out  1  high exactly in cycles where `dq_out` is valid.
- `init_done`  out  1  high once a valid MRS has been accepted.
- `error`  out  1  one-cycle pulse per protocol violation.
- `err_code`  out  3  code of the most recent violation; holds until the next violation or reset.
- `refresh_count`  out  16  accepted REF commands; wraps at 0xFFFF->0.

## Operation
- Command decode, with {cs_n, ras_n, cas_n, we_n}:
  - Ignored cycles: `clock_enable`=0 or `cs_n`=1.
  - 0111 NOP, 0010 PRE, 0001 REF, 0000 MRS, 0011 ACT, 0101 READ, 0100 WRITE.
  - Any other encoding is a NOP.
- Per-bank state: open flag, plus a saturating cycles-since-ACT counter (4 bits).
- PRE: A10=1 closes all banks; A10=0 closes `bank_addr` only. Closing an already-closed bank is legal.
- REF: increments `refresh_count`. Error 5 if any bank is open.
- MRS:
  - `addr[6:4]` selects CAS latency. Only 2 and 3 are legal.
  - `addr[2:0]` is burst length and must be 000.
  - Illegal values, or any bank open, give error 6.
  - A legal MRS sets CL and `init_done`.
- ACT: opens a bank and records the row. Errors:
  - 1 if `init_done`=0.
  - 3 if the bank is already open.
- READ/WRITE: storage index = {bank, open_row[MEM_ROW_BITS-1:0], addr[MEM_COL_BITS-1:0]}. Errors:
  - 1 if `init_done`=0.
  - 2 if the bank is closed.
  - 4 if fewer than TRCD cycles have elapsed since ACT.
- Auto-precharge: A10=1 on READ/WRITE closes the bank at the end of the command cycle.
- Erroneous commands are dropped with no state, storage or pipeline change. If several checks fail, the lowest code is reported.
- WRITE: updates the high byte unless `data_mask_high`; updates the low byte unless `data_mask_low`.
- READ:
  - The array is read in the command cycle; data enters a 3-deep latency pipeline (valid + 16-bit data).
  - Back-to-back READs stream on consecutive cycles.
  - A READ never sees a WRITE issued after it.
- Reset:
  - Banks closed, CL=3, pipeline flushed.
  - `dq_out`=0, `dq_oe`=0, `init_done`=0, `error`=0, `err_code`=0, `refresh_count`=0.
  - Storage contents are retained.
  - Reset during an in-flight read drops that read; `dq_oe` stays 0.

## Timing
- READ sampled at edge n: `dq_out`/`dq_oe` are valid during the cycle following edge n+CL-1, which is where the controller samples its READ_READ state for CL=3.
- With ACT at edge a, READ/WRITE is legal at edge n when n-a >= TRCD. The controller's sequence is ACT, NOP, NOP, CAS, giving a gap of 3.
- WRITE at edge n: storage is updated at edge n. A READ of the same address at edge n+1 returns the new data.
- `error` and `err_code` register at the edge that samples the offending command.
- `init_done` rises at the edge that samples a legal MRS.
- When `dq_oe`=0, `dq_out` is 0.

## Test plan
- Init: PRE(A10=1), REF, REF, MRS addr=0x230 -> `init_done`=1, `refresh_count`=2, CL=3, no `error`.
- Write/read, CL3:
  - ACT bank1 row5; WRITE col3 0xBEEF (A10=1) 3 cycles later.
  - ACT; READ col3 -> `dq_out`=0xBEEF with `dq_oe` high only in the cycle after edge n+2.
  - Bank closed after each access.
- CL2 streaming: MRS CL=2; two READs on consecutive edges -> two consecutive valid beats, starting in the cycle after edge n+1.
- Byte masks: write 0x1234, then write 0xABCD with `data_mask_low`=1 -> read returns 0xAB34.
- Errors:
  - ACT before MRS -> `error` pulse, `err_code`=1.
  - READ to a closed bank -> code 2.
  - READ 2 cycles after ACT -> code 4; no `dq_oe`.
- Reset mid-read: assert `rst` one edge after READ -> `dq_oe` never rises, `init_done`=0; after re-init, the previously written data is still readable.
